// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite master: FSM states, AXI response codes,
// default protection bits and a response classification helper.
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } axil_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master bridging a simple cmd/rsp handshake.
// Define AXIL_MASTER_ERRCNT_EN to add the saturating err_count output.
module axil_master
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
`ifdef AXIL_MASTER_ERRCNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  axil_state_t           state_r;
  logic                  cmd_ready_r;
  logic                  write_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_WIDTH-1:0] wstrb_r;
  logic                  awvalid_r;
  logic                  wvalid_r;
  logic                  bready_r;
  logic                  arvalid_r;
  logic                  rready_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic [1:0]            rsp_resp_r;

  // A handshake channel counts as done once its valid has already dropped
  // or is being accepted this cycle.
  logic aw_done_s;
  logic w_done_s;

  assign aw_done_s = !awvalid_r || m_axil_awready;
  assign w_done_s  = !wvalid_r  || m_axil_wready;

  // Transaction FSM: captures the command, sequences AXI channels, holds response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      write_r     <= 1'b0;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
      wstrb_r     <= {STRB_WIDTH{1'b0}};
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_resp_r  <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            write_r     <= cmd_write;
            addr_r      <= cmd_addr;
            wdata_r     <= cmd_wdata;
            wstrb_r     <= cmd_wstrb;
            if (cmd_write) begin
              state_r   <= ST_WRITE;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
            end else begin
              state_r   <= ST_RADDR;
              arvalid_r <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (awvalid_r && m_axil_awready) begin
            awvalid_r <= 1'b0;
          end
          if (wvalid_r && m_axil_wready) begin
            wvalid_r <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            state_r  <= ST_WRESP;
            bready_r <= 1'b1;
          end
        end
        ST_WRESP: begin
          if (m_axil_bvalid && bready_r) begin
            state_r     <= ST_RESP;
            bready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_resp_r  <= m_axil_bresp;
          end
        end
        ST_RADDR: begin
          if (arvalid_r && m_axil_arready) begin
            state_r   <= ST_RDATA;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end
        end
        ST_RDATA: begin
          if (m_axil_rvalid && rready_r) begin
            state_r     <= ST_RESP;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= m_axil_rdata;
            rsp_resp_r  <= m_axil_rresp;
          end
        end
        ST_RESP: begin
          if (rsp_valid_r && rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIL_MASTER_ERRCNT_EN
  logic [15:0] err_cnt_r;
  logic        err_hit_s;

  assign err_hit_s = ((state_r == ST_WRESP) && m_axil_bvalid && bready_r &&
                      resp_is_err(m_axil_bresp)) ||
                     ((state_r == ST_RDATA) && m_axil_rvalid && rready_r &&
                      resp_is_err(m_axil_rresp));

  // Saturating count of non-OKAY responses accepted from the slave.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_r <= 16'h0000;
    end else if (err_hit_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end
  end

  assign err_count = err_cnt_r;
`endif

  assign cmd_ready      = cmd_ready_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_write      = write_r;
  assign rsp_rdata      = rsp_rdata_r;
  assign rsp_resp       = rsp_resp_r;
  assign m_axil_awaddr  = addr_r;
  assign m_axil_awprot  = PROT_DEFAULT;
  assign m_axil_awvalid = awvalid_r;
  assign m_axil_wdata   = wdata_r;
  assign m_axil_wstrb   = wstrb_r;
  assign m_axil_wvalid  = wvalid_r;
  assign m_axil_bready  = bready_r;
  assign m_axil_araddr  = addr_r;
  assign m_axil_arprot  = PROT_DEFAULT;
  assign m_axil_arvalid = arvalid_r;
  assign m_axil_rready  = rready_r;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: vector table against a small AXI-Lite RAM
// slave with programmable ready delays, plus reset corner sequences.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
`ifdef AXIL_MASTER_ERRCNT_EN
  logic [15:0] err_count;
  int          err_exp = 0;
`endif

  always #5 clk = ~clk;

  axil_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready)
`ifdef AXIL_MASTER_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model state, driven from one process on the falling edge.
  logic [31:0] mem [8];
  int          aw_dly = 0, w_dly = 0;
  logic [1:0]  slv_resp = 2'b00;
  logic        b_hold = 1'b0;
  int          aw_cyc = 0, w_cyc = 0, b_cnt = 0;

  initial begin : slave
    int aw_cnt, w_cnt;
    logic got_aw, got_w, got_ar, b_hs, r_hs;
    logic [4:0] aw_l, ar_l;
    logic [31:0] wd_l;
    logic [3:0] ws_l;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
    aw_cnt = 0; w_cnt = 0; got_aw = 0; got_w = 0; got_ar = 0; b_hs = 0; r_hs = 0;
    aw_l = 0; ar_l = 0; wd_l = 0; ws_l = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; got_aw = 0; got_w = 0; got_ar = 0; b_hs = 0; r_hs = 0;
      end else begin
        if (awvalid) aw_cyc++;
        if (wvalid) w_cyc++;
        if (b_hs) begin b_cnt++; bvalid = 0; b_hs = 0; end
        if (r_hs) begin rvalid = 0; r_hs = 0; end
        if (awready) begin got_aw = 1; awready = 0; aw_cnt = 0; end
        else if (awvalid) begin
          if (aw_cnt >= aw_dly) begin awready = 1; aw_l = awaddr; end
          else aw_cnt++;
        end
        if (wready) begin got_w = 1; wready = 0; w_cnt = 0; end
        else if (wvalid) begin
          if (w_cnt >= w_dly) begin wready = 1; wd_l = wdata; ws_l = wstrb; end
          else w_cnt++;
        end
        if (arready) begin got_ar = 1; arready = 0; end
        else if (arvalid) begin arready = 1; ar_l = araddr; end
        if (got_aw && got_w && !bvalid && !b_hold) begin
          for (int i = 0; i < 4; i++)
            if (ws_l[i]) mem[aw_l[4:2]][8*i +: 8] = wd_l[8*i +: 8];
          bresp = slv_resp; bvalid = 1; got_aw = 0; got_w = 0;
        end
        if (got_ar && !rvalid) begin
          rdata = mem[ar_l[4:2]]; rresp = slv_resp; rvalid = 1; got_ar = 0;
        end
        b_hs = bvalid && bready;
        r_hs = rvalid && rready;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  resp;
    int          rsp_dly;
    int          exp_lat;
    int          exp_aw;
    int          exp_w;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  // Issue one command, check latency, response fields, hold behaviour, channel counts.
  task automatic run_vec(input vec_t v);
    int lat, aw0, w0, b0;
    logic [31:0] first_rdata;
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_cnt;
    aw_dly = v.aw_dly; w_dly = v.w_dly; slv_resp = v.resp;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.strb;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, v.exp_lat);
    chk("rsp_write", {31'b0, rsp_write}, {31'b0, v.wr});
    chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, v.resp});
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    first_rdata = v.exp_rdata;
    for (int k = 0; k < v.rsp_dly; k++) begin
      @(negedge clk);
      chk("rsp_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_hold_rdata", rsp_rdata, first_rdata);
      chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_released", {31'b0, rsp_valid}, 32'd0);
    chk("aw_cycles", aw_cyc - aw0, v.exp_aw);
    chk("w_cycles", w_cyc - w0, v.exp_w);
    chk("b_count", b_cnt - b0, v.wr ? 32'd1 : 32'd0);
`ifdef AXIL_MASTER_ERRCNT_EN
    if (v.resp != 2'b00) err_exp++;
    chk("err_count", {16'b0, err_count}, err_exp);
`endif
  endtask

  initial begin
    int t;
    logic seen;
    //           wr addr   wdata          strb aw w resp  rdly lat aw w rdata
    vecs[0] = '{1, 5'h04, 32'd2345,      4'hF, 0, 0, 2'b00, 0, 3, 1, 1, 32'h0};
    vecs[1] = '{0, 5'h04, 32'h0,         4'h0, 0, 0, 2'b00, 0, 3, 0, 0, 32'd2345};
    vecs[2] = '{1, 5'h08, 32'hA5A5_5A5A, 4'hF, 3, 0, 2'b00, 0, 6, 4, 1, 32'h0};
    vecs[3] = '{1, 5'h08, 32'h1234_5678, 4'h5, 0, 2, 2'b00, 0, 5, 1, 3, 32'h0};
    vecs[4] = '{0, 5'h08, 32'h0,         4'h0, 0, 0, 2'b00, 5, 3, 0, 0, 32'hA534_5A78};
    vecs[5] = '{0, 5'h0C, 32'h0,         4'h0, 0, 0, 2'b10, 0, 3, 0, 0, 32'h0};
    vecs[6] = '{0, 5'h0C, 32'h0,         4'h0, 0, 0, 2'b10, 0, 3, 0, 0, 32'h0};
    vecs[7] = '{1, 5'h1C, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b11, 0, 3, 1, 1, 32'h0};
    vecs[8] = '{0, 5'h1C, 32'h0,         4'h0, 0, 0, 2'b00, 0, 3, 0, 0, 32'hDEAD_BEEF};
    vecs[9] = '{0, 5'h00, 32'h0,         4'h0, 0, 0, 2'b00, 0, 3, 0, 0, 32'h0};

    rst = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_valids", {28'b0, awvalid, wvalid, arvalid, bready | rready}, 32'd0);
    rst = 1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("post_rst_payload", {rsp_rdata[26:0], awaddr}, 32'd0);
    chk("prot_zero", {26'b0, awprot, arprot}, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset while waiting for the write response.
    b_hold = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 5'h10; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    t = 0;
    while (!bready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("wresp_reached", {31'b0, bready}, 32'd1);
    rst = 0;
    @(negedge clk);
    chk("mid_rst_valids", {27'b0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
`ifdef AXIL_MASTER_ERRCNT_EN
    chk("err_count_rst", {16'b0, err_count}, 32'd0);
    err_exp = 0;
`endif
    rst = 1;
    b_hold = 0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("no_rsp_after_abort", {31'b0, seen}, 32'd0);
    run_vec(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data width (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, byte address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-007 SHALL have ports cmd_write in 1 (1=write), cmd_addr in ADDR_WIDTH, cmd_wdata in DATA_WIDTH, cmd_wstrb in STRB_WIDTH.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-009 SHALL have ports rsp_write out 1, rsp_rdata out DATA_WIDTH, rsp_resp out 2: completed operation type, read data, AXI response code.
REQ-010 SHALL have AXI-Lite master ports m_axil_aw{addr,prot,valid,ready}, m_axil_w{data,strb,valid,ready}, m_axil_b{resp,valid,ready}, m_axil_ar{addr,prot,valid,ready}, m_axil_r{data,resp,valid,ready}; widths per AXI4-Lite; *ready for aw/w/ar and b/r valid/resp/data are inputs.

Function
REQ-011 SHALL be an FSM with states IDLE, WRITE, WRESP, RADDR, RDATA, RESP; one transaction outstanding at a time.
REQ-012 SHALL assert cmd_ready only in IDLE; cmd_valid&&cmd_ready captures all cmd_* into registers.
REQ-013 SHALL, on captured write, go to WRITE next cycle with awvalid=1 and wvalid=1 simultaneously; aw/w payloads from captured registers.
REQ-014 SHALL, in WRITE, drop awvalid the cycle after awvalid&&awready and wvalid the cycle after wvalid&&wready, independently; either order or same cycle accepted.
REQ-015 SHALL move WRITE->WRESP once both handshakes done; bready=1 only in WRESP; bvalid&&bready captures bresp, goes to RESP.
REQ-016 SHALL, on captured read, go to RADDR with arvalid=1; arvalid&&arready -> RDATA; rready=1 only in RDATA; rvalid&&rready captures rdata/rresp, goes to RESP.
REQ-017 SHALL, in RESP, hold rsp_valid=1 with stable payload until rsp_ready; then IDLE; rsp_rdata=0 for writes.
REQ-018 SHALL never drop a valid (aw/w/ar/rsp) before its handshake, nor change its payload while valid.
REQ-019 SHALL drive awprot=arprot=3'b000 constantly.
REQ-020 SHALL ignore bvalid/rvalid outside WRESP/RDATA (ready low there).
REQ-021 SHALL give minimum latency cmd accept -> rsp_valid of 3 cycles with zero-wait slave (IDLE, WRITE/RADDR, WRESP/RDATA, RESP); back-to-back commands separated by at least one IDLE cycle.

Reset
REQ-022 SHALL, while rst=0 at a clock edge, enter IDLE and clear all valid/ready outputs except cmd_ready, which is 1 from the first cycle after reset release; payload registers cleared to 0.
REQ-023 SHALL abandon any in-flight transaction on reset mid-operation without producing a response.

Configuration
REQ-024 SHALL, with AXIL_MASTER_ERRCNT_EN defined, provide output err_count (16 bits), incremented on each captured bresp/rresp != 2'b00, saturating at 16'hFFFF, cleared by reset.
REQ-025 SHALL, without AXIL_MASTER_ERRCNT_EN, omit err_count port and logic entirely; all other behaviour identical.

Structure
REQ-026 SHALL place FSM state enum, AXI response constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and PROT default in shared package axil_pkg.
REQ-027 SHALL be a single module; no sub-module needed.

Verification
REQ-028 Write addr 5'h04, data 32'd2345, strb 4'hF against axil_ram, zero wait -> AW/W same cycle, rsp_valid 3 cycles after accept, rsp_write=1, rsp_resp=2'b00.
REQ-029 Read addr 5'h04 after REQ-028 -> rsp_rdata=32'd2345, rsp_resp=2'b00, rsp_write=0.
REQ-030 Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held stable 4 cycles, single B accepted.
REQ-031 Read with rsp_ready low 5 cycles -> rsp_valid and rsp_rdata stable throughout, cmd_ready=0 until rsp handshake.
REQ-032 Slave returns rresp=2'b10 twice (ERRCNT_EN defined) -> rsp_resp=2'b10, err_count=2; reset -> err_count=0.
REQ-033 Assert rst=0 in WRESP -> next cycle IDLE, all AXI valids/readies 0, no rsp_valid pulse.
